// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC register, ROM address, IF/ID register.
// Optional perf counters (fetch_cnt, bubble_cnt) enabled by IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] iaddr,
  input  logic [31:0] instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_err
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        advance;

  assign iaddr   = pc;
  assign pc_next = pc + 32'd4;
  assign advance = !redirect && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      if_id_pc     <= '0;
      if_id_pc4    <= '0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      // Squash the wrong-path fetch; if_id_pc/pc4 keep their old values.
      pc           <= {redirect_pc[31:2], 2'b00};
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      misalign_err <= |redirect_pc[1:0];
    end else begin
      misalign_err <= 1'b0;
      if (!stall) begin
        pc          <= pc_next;
        if_id_pc    <= pc;
        if_id_pc4   <= pc_next;
        if_id_instr <= instr;
        if_id_valid <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (advance)
        fetch_cnt <= fetch_cnt + 1'b1;
      if (!advance)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (CNT_W > 0) && advance;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed plan with literal pins, then random
// stimulus checked every cycle against a behavioural fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] iaddr, instr;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, misalign_err;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h35A1_C0DE;
  endfunction

  assign instr = rom(iaddr);

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .iaddr(iaddr), .instr(instr),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .misalign_err(misalign_err)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the stage must hold after each edge.
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
  logic        m_valid, m_mis;
  logic [31:0] m_fc, m_bc;
  bit          m_init = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP;
      m_valid = 0; m_mis = 0; m_fc = 0; m_bc = 0; m_init = 1;
    end else if (m_init) begin
      if (redirect) begin
        m_bc++;
        m_mis = (redirect_pc % 4) != 0;
        m_pc = redirect_pc - (redirect_pc % 4);
        m_instr = NOP;
        m_valid = 0;
      end else begin
        m_mis = 0;
        if (stall) m_bc++;
        else begin
          m_ifpc = m_pc;
          m_ifpc4 = m_pc + 4;
          m_instr = rom(m_pc);
          m_valid = 1;
          m_fc++;
          m_pc = m_pc + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("iaddr", iaddr, m_pc);
      chk("if_id_pc", if_id_pc, m_ifpc);
      chk("if_id_pc4", if_id_pc4, m_ifpc4);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_fc);
      chk("bubble_cnt", bubble_cnt, m_bc);
`endif
    end
  end

  task automatic step(input logic r, input logic s, input logic d,
                      input logic [31:0] p);
    rst = r; stall = s; redirect = d; redirect_pc = p;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0000_0013);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    step(0, 0, 0, 0);
    chk("run1_iaddr", iaddr, 32'h4);
    chk("run1_pc", if_id_pc, 32'h0);
    chk("run1_valid", 32'(if_id_valid), 32'h1);
    chk("run1_instr", if_id_instr, 32'h35A1_C0DD);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    chk("stall_iaddr", iaddr, 32'h8);
    chk("stall_pc", if_id_pc, 32'h4);
`ifdef IF_PERF_CNT_EN
    chk("stall_bcnt", bubble_cnt, 32'd3);
`endif
    step(0, 0, 0, 0);
    chk("unstall_pc", if_id_pc, 32'h8);
    chk("pre_redir_iaddr", iaddr, 32'hC);
    step(0, 0, 1, 32'h40);
    chk("redir_iaddr", iaddr, 32'h40);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    chk("redir_instr", if_id_instr, 32'h0000_0013);
    step(0, 0, 0, 0);
    chk("post_redir_pc", if_id_pc, 32'h40);
    chk("post_redir_valid", 32'(if_id_valid), 32'h1);
    step(0, 1, 1, 32'h20);
    chk("rs_iaddr", iaddr, 32'h20);
    chk("rs_valid", 32'(if_id_valid), 32'h0);
    step(0, 0, 1, 32'h22);
    chk("mis_iaddr", iaddr, 32'h20);
    chk("mis_set", 32'(misalign_err), 32'h1);
    step(0, 0, 0, 0);
    chk("mis_clr", 32'(misalign_err), 32'h0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_iaddr", iaddr, 32'h0);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    step(1, 1, 0, 0);
    chk("mid_rst_iaddr", iaddr, 32'h0);
    chk("mid_rst_valid", 32'(if_id_valid), 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("mid_rst_fcnt", fetch_cnt, 32'h0);
    chk("mid_rst_bcnt", bubble_cnt, 32'h0);
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = $urandom;
      if ($urandom_range(0, 7) == 0) p = 32'hFFFF_FFF0 | (p & 32'hF);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, p);
    end
    step(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the RV32I pipelined CPU. It holds the program counter and drives the word address to the combinational instruction ROM. It captures the returned instruction into the IF/ID pipeline register. It also handles stall holds and branch/jump redirects (with flush) from downstream stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0013, bubble instruction inserted into IF/ID (ADDI x0,x0,0).
CNT_W, 32, width of the performance counters (used only when IF_PERF_CNT_EN is defined).

Ports:
clk  in  1  Pipeline clock; all state updates on the rising edge.
rst  in  1  Synchronous, active-high reset.
stall  in  1  Hazard-unit hold; freezes PC and IF/ID.
redirect  in  1  Branch taken or jump resolved in EX; load new PC and flush.
redirect_pc  in  32  Redirect target byte address.
iaddr  out  32  Instruction byte address to the ROM; equals the PC register, combinational.
instr  in  32  Instruction returned combinationally by the ROM for iaddr.
if_id_pc  out  32  PC of the instruction held in IF/ID.
if_id_pc4  out  32  if_id_pc + 4; used as the JAL/JALR link value.
if_id_instr  out  32  Instruction held in IF/ID.
if_id_valid  out  1  1 when IF/ID holds a real instruction; 0 for a bubble.
misalign_err  out  1  Registered one-cycle pulse when an accepted redirect_pc has bits [1:0] != 0.
fetch_cnt  out  CNT_W  Valid fetches counter (only when IF_PERF_CNT_EN is defined).
bubble_cnt  out  CNT_W  Stall/flush cycles counter (only when IF_PERF_CNT_EN is defined).

Behaviour:
- Priority per rising edge: rst > redirect > stall > normal advance.
- Reset state:
  - pc = RESET_PC
  - if_id_pc = 0, if_id_pc4 = 0, if_id_instr = NOP_INSTR
  - if_id_valid = 0, misalign_err = 0
  - counters = 0
- Reset applies regardless of stall or redirect.
- iaddr = pc with no register in between. The ROM indexes by iaddr[31:2].
- Normal advance (no rst, redirect or stall):
  - pc <= pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - if_id_pc <= pc, if_id_pc4 <= pc + 4, if_id_instr <= instr, if_id_valid <= 1.
- Latency: the instruction at address A appears in IF/ID on the edge after pc == A.
- First real instruction: if_id_valid first rises on the first edge after rst deasserts. IF/ID then holds the instruction from RESET_PC.
- Stall, without redirect:
  - pc and all IF/ID outputs hold their values, including if_id_valid.
  - instr is ignored.
- Redirect, regardless of stall:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID is flushed: if_id_instr = NOP_INSTR, if_id_valid = 0. if_id_pc and if_id_pc4 hold their previous values.
  - This squashes the wrong-path instruction currently fetched.
- Redirect with stall in the same cycle: the redirect wins. The PC updates and IF/ID is flushed; it does not hold.
- Back-to-back redirects: each one loads the PC; IF/ID stays a bubble until the first normal advance.
- misalign_err: set to 1 for exactly one cycle after an accepted redirect with redirect_pc[1:0] != 0, otherwise 0. The PC is still force-aligned.
- No combinational path exists from stall or redirect to any if_id_* output. Only iaddr is combinational, from the pc register.

Optional Feature:
IF_PERF_CNT_EN
- When defined:
  - fetch_cnt increments on every edge where IF/ID loads with if_id_valid <= 1.
  - bubble_cnt increments on every non-reset edge where stall or redirect is asserted.
  - Both counters wrap at 2^CNT_W and clear on rst.
- When not defined: both ports and the counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then 4 free-running cycles: iaddr = 0, 4, 8, 12; IF/ID shows pc 0/4/8 with valid = 1, starting one cycle after rst drops. Before the first edge, if_id_instr = 32'h00000013 and valid = 0.
- Hold stall for 3 cycles at pc = 8: iaddr stays 8; IF/ID stays at pc 4 with its instruction. On release, the next edge shows if_id_pc = 8; with IF_PERF_CNT_EN defined, bubble_cnt = 3.
- redirect = 1 with redirect_pc = 32'h0000_0040 at pc = 12: next cycle pc = 32'h40, if_id_valid = 0, if_id_instr = NOP_INSTR. The following edge gives if_id_pc = 32'h40, valid = 1.
- redirect and stall both asserted, redirect_pc = 32'h0000_0020: pc = 32'h20 and IF/ID is flushed (valid = 0), showing the redirect overrides the stall.
- redirect_pc = 32'h0000_0022: pc = 32'h20, misalign_err = 1 for exactly one cycle, then 0.
- Force pc to 32'hFFFF_FFFC via redirect, then advance once: pc wraps to 0, if_id_pc = 32'hFFFF_FFFC, if_id_pc4 = 0.
- Assert rst mid-stream while stall = 1: next cycle pc = RESET_PC, valid = 0, and counters are 0.
